// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch core.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Out-of-range nibbles load as 9 so a digit never leaves the BCD range.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_core_if.sv
// Control/status bundle between the board top level and the stopwatch core.
interface bcd_stopwatch_core_if #(
  parameter int DIGITS = 4
) ();

  logic                  start_stop;
  logic                  clear;
  logic                  lap;
  logic                  dir;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   count_o;
  logic                  running;
  logic                  done;
  logic                  lap_active;

  modport master (
    output start_stop, clear, lap, dir, preset,
    input  count_o, running, done, lap_active
  );

  modport slave (
    input  start_stop, clear, lap, dir, preset,
    output count_o, running, done, lap_active
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit: loadable, steps up or down with wrap when enabled.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t digit,
  output logic       term
);

  // Digit register: load beats step; wrap 9->0 up, 0->9 down.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      if (!dir) digit <= (digit == BCD_MAX)  ? BCD_ZERO : digit + 4'd1;
      else      digit <= (digit == BCD_ZERO) ? BCD_MAX  : digit - 4'd1;
    end
  end

  assign term = ((digit == BCD_MAX) && !dir) || ((digit == BCD_ZERO) && dir);

endmodule

// File: rtl/bcd_stopwatch_core.sv
// N-digit BCD stopwatch / countdown timer, single clock, enable-based carries.
// Optional lap freeze display is built when BCD_STOPWATCH_LAP_EN is defined.
//
//   state  | meaning
//   IDLE   | stopped; count holds cleared/preset value, dir latched on start
//   RUN    | prescaler advancing, digits step on each tick
//   PAUSED | prescaler and count frozen
//   DONE   | terminal value reached (all-9 up, zero down); only clear exits
module bcd_stopwatch_core
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000
) (
  input logic                   clk,
  input logic                   reset,
  bcd_stopwatch_core_if.slave   bus
);

  localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

  state_e              state_q, state_d;
  logic [PSC_W-1:0]    psc_q, psc_d;
  logic                dir_q, dir_d;
  logic                tick;
  logic [DIGITS-1:0]   term, carry, dig_en;
  logic [4*DIGITS-1:0] count, load_val, shown, count_o_q;
  logic                all_term, hit_zero, count_zero;
  logic                running_q, done_q, lap_q;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign load_val[4*k +: 4] = bus.dir ? bcd_clamp(bus.preset[4*k +: 4]) : BCD_ZERO;

    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .en       (dig_en[k]),
      .dir      (dir_q),
      .load     (bus.clear),
      .load_val (load_val[4*k +: 4]),
      .digit    (count[4*k +: 4]),
      .term     (term[k])
    );
  end

  // Carry-enable chain: digit k may step once every lower digit is terminal.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int k = 1; k < DIGITS; k++) carry[k] = carry[k-1] & term[k-1];
  end

  assign all_term   = carry[DIGITS-1] & term[DIGITS-1];
  assign hit_zero   = dir_q && (count[3:0] == 4'd1) && ((count >> 4) == '0);
  assign count_zero = (count == '0);
  // A tick at the terminal value saturates instead of wrapping.
  assign dig_en     = (tick && !all_term) ? carry : '0;

  // Next-state, prescaler and tick decode.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    dir_d   = dir_q;
    tick    = 1'b0;
    if (state_q == RUN) begin
      if (psc_q == PSC_LAST) begin
        psc_d = '0;
        tick  = 1'b1;
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end
    unique case (state_q)
      IDLE: if (bus.start_stop) begin
        dir_d   = bus.dir;
        psc_d   = '0;
        state_d = (bus.dir && count_zero) ? DONE : RUN;
      end
      RUN: begin
        if (tick && (all_term || hit_zero)) state_d = DONE;
        else if (bus.start_stop)            state_d = PAUSED;
      end
      PAUSED: if (bus.start_stop) state_d = RUN;
      DONE: ;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      psc_d   = '0;
    end
  end

  // State, prescaler, latched direction and registered status decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      psc_q     <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_q     <= psc_d;
      dir_q     <= dir_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  logic [4*DIGITS-1:0] lap_val_q;

  // Lap toggle: capture the live count when freezing the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q     <= 1'b0;
      lap_val_q <= '0;
    end else if (bus.clear) begin
      lap_q     <= 1'b0;
    end else if (bus.lap && !bus.start_stop && ((state_q == RUN) || (state_q == PAUSED))) begin
      lap_q <= !lap_q;
      if (!lap_q) lap_val_q <= count;
    end
  end

  assign shown = lap_q ? lap_val_q : count;
`else
  logic unused_lap;
  assign unused_lap = bus.lap;
  assign lap_q      = 1'b0;
  assign shown      = count;
`endif

  // Display register.
  always_ff @(posedge clk) begin
    if (reset) count_o_q <= '0;
    else       count_o_q <= shown;
  end

  assign bus.count_o    = count_o_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.lap_active = lap_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Directed bench for bcd_stopwatch_core (DIGITS=4, TICK_DIV=4).
// With TICK_DIV=4 a tick lands 4*k edges after the start edge; count_o lags by one edge.
module tb_bcd_stopwatch_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  bcd_stopwatch_core_if #(.DIGITS(4)) bus ();

  bcd_stopwatch_core #(.DIGITS(4), .TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start_stop = 1'b1;
    @(negedge clk);
    bus.start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic pulse_lap();
    bus.lap = 1'b1;
    @(negedge clk);
    bus.lap = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    vectors++;
    if (bus.count_o !== 16'h0000) begin miscompares++; $display("FAIL reset_count got=%h exp=0000", bus.count_o); end
    vectors++;
    if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.lap_active !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got run=%b done=%b lap=%b exp=000", bus.running, bus.done, bus.lap_active);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_up_count();
    pulse_start();
    step(5);
    vectors++;
    if (bus.count_o !== 16'h0001) begin miscompares++; $display("FAIL up_first_tick got=%h exp=0001", bus.count_o); end
    step(36);
    vectors++;
    if (bus.count_o !== 16'h0010 || bus.running !== 1'b1) begin
      miscompares++; $display("FAIL up_40_cycles got=%h run=%b exp=0010 run=1", bus.count_o, bus.running);
    end
    reset = 1'b1;
    step(1);
    vectors++;
    if (bus.count_o !== 16'h0000 || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_run got=%h run=%b exp=0000 run=0", bus.count_o, bus.running);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_saturate();
    bus.dir = 1'b0;
    pulse_clear();
    pulse_start();
    step(39997);
    vectors++;
    if (bus.count_o !== 16'h9999 || bus.running !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL sat_9999 got=%h run=%b done=%b exp=9999 run=1 done=0", bus.count_o, bus.running, bus.done);
    end
    step(3);
    vectors++;
    if (bus.done !== 1'b1 || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL sat_done got run=%b done=%b exp run=0 done=1", bus.running, bus.done);
    end
    step(20);
    vectors++;
    if (bus.count_o !== 16'h9999) begin miscompares++; $display("FAIL sat_hold got=%h exp=9999", bus.count_o); end
    pulse_start();
    step(8);
    vectors++;
    if (bus.done !== 1'b1 || bus.count_o !== 16'h9999) begin
      miscompares++; $display("FAIL done_ignores_start got=%h done=%b exp=9999 done=1", bus.count_o, bus.done);
    end
  endtask

  task automatic test_countdown();
    bus.dir    = 1'b1;
    bus.preset = 16'h0102;
    pulse_clear();
    step(1);
    vectors++;
    if (bus.count_o !== 16'h0102 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL down_load got=%h done=%b exp=0102 done=0", bus.count_o, bus.done);
    end
    pulse_start();
    step(5);
    vectors++;
    if (bus.count_o !== 16'h0101) begin miscompares++; $display("FAIL down_tick1 got=%h exp=0101", bus.count_o); end
    step(8);
    vectors++;
    if (bus.count_o !== 16'h0099) begin miscompares++; $display("FAIL down_tick3 got=%h exp=0099", bus.count_o); end
    step(395);
    vectors++;
    if (bus.done !== 1'b1 || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL down_done got run=%b done=%b exp run=0 done=1", bus.running, bus.done);
    end
    step(1);
    vectors++;
    if (bus.count_o !== 16'h0000) begin miscompares++; $display("FAIL down_zero got=%h exp=0000", bus.count_o); end
  endtask

  task automatic test_dir_latch();
    bus.dir = 1'b0;
    pulse_clear();
    pulse_start();
    step(9);
    bus.dir = 1'b1;
    step(4);
    vectors++;
    if (bus.count_o !== 16'h0003) begin miscompares++; $display("FAIL dir_ignored_in_run got=%h exp=0003", bus.count_o); end
    bus.dir = 1'b0;
  endtask

  task automatic test_pause();
    bus.dir = 1'b0;
    pulse_clear();
    pulse_start();
    step(22);
    pulse_start();
    step(100);
    vectors++;
    if (bus.count_o !== 16'h0005 || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL pause_hold got=%h run=%b exp=0005 run=0", bus.count_o, bus.running);
    end
    pulse_start();
    step(1);
    vectors++;
    if (bus.count_o !== 16'h0005 || bus.running !== 1'b1) begin
      miscompares++; $display("FAIL resume_pre got=%h run=%b exp=0005 run=1", bus.count_o, bus.running);
    end
    step(1);
    vectors++;
    if (bus.count_o !== 16'h0006) begin miscompares++; $display("FAIL resume_tick got=%h exp=0006", bus.count_o); end
  endtask

  task automatic test_priority();
    bus.clear      = 1'b1;
    bus.start_stop = 1'b1;
    @(negedge clk);
    bus.clear      = 1'b0;
    bus.start_stop = 1'b0;
    step(1);
    vectors++;
    if (bus.count_o !== 16'h0000 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++; $display("FAIL clear_beats_start got=%h run=%b done=%b exp=0000 run=0 done=0", bus.count_o, bus.running, bus.done);
    end
    step(10);
    vectors++;
    if (bus.count_o !== 16'h0000) begin miscompares++; $display("FAIL idle_after_clear got=%h exp=0000", bus.count_o); end
  endtask

  task automatic test_preset_clamp();
    bus.dir    = 1'b1;
    bus.preset = 16'hA3F0;
    pulse_clear();
    step(1);
    vectors++;
    if (bus.count_o !== 16'h9390) begin miscompares++; $display("FAIL preset_clamp got=%h exp=9390", bus.count_o); end
    bus.preset = 16'h0000;
    pulse_clear();
    pulse_start();
    vectors++;
    if (bus.done !== 1'b1 || bus.running !== 1'b0) begin
      miscompares++; $display("FAIL zero_start got run=%b done=%b exp run=0 done=1", bus.running, bus.done);
    end
    bus.dir = 1'b0;
  endtask

  task automatic test_lap();
    bus.dir = 1'b0;
    pulse_clear();
    pulse_lap();
    vectors++;
    if (bus.lap_active !== 1'b0) begin miscompares++; $display("FAIL lap_idle_ignored got=%b exp=0", bus.lap_active); end
    pulse_start();
    step(29);
`ifdef BCD_STOPWATCH_LAP_EN
    pulse_lap();
    step(40);
    vectors++;
    if (bus.count_o !== 16'h0007 || bus.lap_active !== 1'b1) begin
      miscompares++; $display("FAIL lap_freeze got=%h lap=%b exp=0007 lap=1", bus.count_o, bus.lap_active);
    end
    pulse_lap();
    step(1);
    vectors++;
    if (bus.count_o !== 16'h0017 || bus.lap_active !== 1'b0) begin
      miscompares++; $display("FAIL lap_release got=%h lap=%b exp=0017 lap=0", bus.count_o, bus.lap_active);
    end
`else
    pulse_lap();
    step(10);
    vectors++;
    if (bus.count_o !== 16'h0009 || bus.lap_active !== 1'b0) begin
      miscompares++; $display("FAIL lap_disabled got=%h lap=%b exp=0009 lap=0", bus.count_o, bus.lap_active);
    end
`endif
    pulse_clear();
  endtask

  initial begin
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
    bus.dir        = 1'b0;
    bus.preset     = 16'h0000;
    test_reset();
    test_up_count();
    test_saturate();
    test_countdown();
    test_dir_latch();
    test_pause();
    test_priority();
    test_preset_clamp();
    test_lap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
